// File: rtl/q_pkg.sv
// Shared widths, action count, FSM encoding and default learning-rate shifts
// for the tabular Q-learning update engine.
package q_pkg;

  localparam int Q_W             = 16;
  localparam int ACT_W           = 4;
  localparam int N_ACT           = 9;
  localparam int ALPHA_SHIFT_DEF = 2;
  localparam int GAMMA_SHIFT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    READ_CUR = 3'd2,
    CUR_WAIT = 3'd3,
    CALC     = 3'd4,
    WRITE    = 3'd5
  } state_t;

  localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(N_ACT - 1);

endpackage

// File: rtl/q_update_alu.sv
// Combinational Q update: q + alpha*(reward + gamma*maxq - q), done in 18-bit
// signed arithmetic and saturated back to the signed Q8.8 range.
module q_update_alu
  import q_pkg::*;
#(
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF,
  parameter int GAMMA_SHIFT = GAMMA_SHIFT_DEF
) (
  input  logic [Q_W-1:0] reward,
  input  logic [Q_W-1:0] maxq,
  input  logic [Q_W-1:0] q_cur,
  output logic [Q_W-1:0] q_new
);

  logic signed [17:0] reward_x;
  logic signed [17:0] maxq_x;
  logic signed [17:0] q_x;
  logic signed [17:0] target;
  logic signed [17:0] delta;
  logic signed [17:0] sum;

  localparam logic signed [17:0] SAT_HI = 18'sd32767;
  localparam logic signed [17:0] SAT_LO = -18'sd32768;

  always_comb begin
    reward_x = {{2{reward[Q_W-1]}}, reward};
    maxq_x   = {{2{maxq[Q_W-1]}}, maxq};
    q_x      = {{2{q_cur[Q_W-1]}}, q_cur};
    // gamma*maxq is formed as maxq minus a shifted copy of itself
    target   = reward_x + maxq_x - (maxq_x >>> GAMMA_SHIFT);
    delta    = target - q_x;
    sum      = q_x + (delta >>> ALPHA_SHIFT);
    if (sum > SAT_HI) begin
      q_new = 16'h7FFF;
    end else if (sum < SAT_LO) begin
      q_new = 16'h8000;
    end else begin
      q_new = sum[Q_W-1:0];
    end
  end

endmodule

// File: rtl/q_update.sv
// Q-table update sequencer: scans Q(s',*) for the max, reads Q(s,a), computes
// the new value in q_update_alu and writes it back to the same slot.
module q_update
  import q_pkg::*;
#(
  parameter int STATE_W     = 8,
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF,
  parameter int GAMMA_SHIFT = GAMMA_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [STATE_W-1:0]       state,
  input  logic [ACT_W-1:0]         action,
  input  logic [STATE_W-1:0]       next_state,
  input  logic [Q_W-1:0]           reward,
  input  logic                     terminal,
  output logic [STATE_W+ACT_W-1:0] mem_addr,
  output logic                     mem_rd_en,
  input  logic [Q_W-1:0]           mem_rdata,
  output logic                     mem_wr_en,
  output logic [Q_W-1:0]           mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ACT_W-1:0]         best_next,
  output logic [Q_W-1:0]           q_new,
  output logic [2:0]               dbg_state
);

  // Memory handshake: a read strobe (mem_rd_en) returns mem_rdata exactly one
  // cycle later with no stall; a write strobe (mem_wr_en) is a single cycle
  // that the memory must accept unconditionally. The two never overlap.

  state_t               state_q;
  state_t               state_d;

  logic [STATE_W-1:0]   s_r;
  logic [ACT_W-1:0]     a_r;
  logic [STATE_W-1:0]   ns_r;
  logic [Q_W-1:0]       reward_r;
  logic [ACT_W-1:0]     scan_k;
  logic                 scan_vld;
  logic [ACT_W-1:0]     scan_slot;
  logic [Q_W-1:0]       maxq_r;
  logic [ACT_W-1:0]     best_r;
  logic [Q_W-1:0]       q_cur_r;
  logic [Q_W-1:0]       q_new_r;
  logic                 err_pulse;
  logic [Q_W-1:0]       alu_q;
  logic                 bad_action;

  assign bad_action = (action > LAST_ACT);

  q_update_alu #(
    .ALPHA_SHIFT(ALPHA_SHIFT),
    .GAMMA_SHIFT(GAMMA_SHIFT)
  ) u_alu (
    .reward(reward_r),
    .maxq  (maxq_r),
    .q_cur (q_cur_r),
    .q_new (alu_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !bad_action) begin
          state_d = terminal ? READ_CUR : SCAN;
        end
      end
      SCAN: begin
        if (scan_k == LAST_ACT) begin
          state_d = READ_CUR;
        end
      end
      READ_CUR: state_d = CUR_WAIT;
      CUR_WAIT: state_d = CALC;
      CALC:     state_d = WRITE;
      WRITE:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r       <= '0;
      a_r       <= '0;
      ns_r      <= '0;
      reward_r  <= '0;
      scan_k    <= '0;
      scan_vld  <= 1'b0;
      scan_slot <= '0;
      maxq_r    <= '0;
      best_r    <= '0;
      q_cur_r   <= '0;
      q_new_r   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      // Read data for slot k lands one cycle after its request
      scan_vld  <= (state_q == SCAN);
      scan_slot <= scan_k;

      if (scan_vld) begin
        if ((scan_slot == '0) || ($signed(mem_rdata) > $signed(maxq_r))) begin
          maxq_r <= mem_rdata;
          best_r <= scan_slot;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (bad_action) begin
              err_pulse <= 1'b1;
            end else begin
              s_r      <= state;
              a_r      <= action;
              ns_r     <= next_state;
              reward_r <= reward;
              scan_k   <= '0;
              if (terminal) begin
                maxq_r <= '0;
                best_r <= '0;
              end
            end
          end
        end
        SCAN:     scan_k  <= scan_k + 1'b1;
        CUR_WAIT: q_cur_r <= mem_rdata;
        CALC:     q_new_r <= alu_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_rd_en = (state_q == SCAN) || (state_q == READ_CUR);
    mem_wr_en = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? q_new_r : '0;
    done      = (state_q == WRITE) || err_pulse;
    err       = err_pulse;
    case (state_q)
      SCAN:            mem_addr = {ns_r, scan_k};
      READ_CUR, WRITE: mem_addr = {s_r, a_r};
      default:         mem_addr = '0;
    endcase
  end

  assign best_next = best_r;
  assign q_new     = q_new_r;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_q_update.sv
// Self-checking bench for q_update: a behavioural Q-table memory, a write
// scoreboard fed at start time, and one task per scenario.
module tb_q_update;
  import q_pkg::*;

  localparam int SW = 8;
  localparam int AW = SW + ACT_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [SW-1:0]  state;
  logic [3:0]     action;
  logic [SW-1:0]  next_state;
  logic [15:0]    reward;
  logic           terminal;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd_en;
  logic [15:0]    mem_rdata;
  logic           mem_wr_en;
  logic [15:0]    mem_wdata;
  logic           busy;
  logic           done;
  logic           err;
  logic [3:0]     best_next;
  logic [15:0]    q_new;
  logic [2:0]     dbg_state;

  logic [15:0]    mem [0:(1<<AW)-1];
  logic [31:0]    exp_q[$];

  int errors = 0;
  int checks = 0;

  q_update #(.STATE_W(SW), .ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .action(action),
    .next_state(next_state), .reward(reward), .terminal(terminal),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .best_next(best_next), .q_new(q_new), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;
  end

  function automatic logic [15:0] model_q(input logic [15:0] q, input logic [15:0] r,
                                          input logic [15:0] m);
    int qi, ri, mi, t, d, s;
    qi = $signed(q);
    ri = $signed(r);
    mi = $signed(m);
    t  = ri + mi - (mi >>> 3);
    d  = t - qi;
    s  = qi + (d >>> 2);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic set_row(input logic [SW-1:0] s, input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3, input logic [15:0] v4,
                         input logic [15:0] v5, input logic [15:0] v6, input logic [15:0] v7,
                         input logic [15:0] v8);
    logic [15:0] row [0:8];
    row = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int k = 0; k < 9; k++) mem[{s, 4'(k)}] = row[k];
  endtask

  // Drives one request, pushes its expected write, then watches the DUT
  // cycle by cycle (cycle 1 = first cycle after the accepting edge).
  task automatic run_txn(input logic [SW-1:0] s, input logic [3:0] a, input logic [SW-1:0] ns,
                         input logic [15:0] r, input logic term, input int repulse_cyc,
                         output int wr_cycle, output int rd_count, output int n_wr,
                         output int done_cycle, output logic saw_err);
    logic [15:0] m;
    logic [3:0]  b;
    logic [31:0] got;
    logic [31:0] want;
    logic        proto_bad;
    wr_cycle = 0; rd_count = 0; n_wr = 0; done_cycle = 0; saw_err = 1'b0; proto_bad = 1'b0;
    if (a <= 4'd8) begin
      m = 16'h0000;
      b = 4'd0;
      if (!term) begin
        m = mem[{ns, 4'd0}];
        for (int k = 1; k < 9; k++) begin
          if ($signed(mem[{ns, 4'(k)}]) > $signed(m)) begin
            m = mem[{ns, 4'(k)}];
            b = 4'(k);
          end
        end
      end
      exp_q.push_back({b, s, a, model_q(mem[{s, a}], r, m)});
    end
    @(negedge clk);
    start = 1'b1; state = s; action = a; next_state = ns; reward = r; terminal = term;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == repulse_cyc);
      state = 8'($urandom_range(0, 255)); action = 4'($urandom_range(0, 8));
      next_state = 8'($urandom_range(0, 255)); reward = 16'($urandom_range(0, 65535));
      terminal = 1'($urandom_range(0, 1));
      if (mem_rd_en && mem_wr_en) proto_bad = 1'b1;
      if ((mem_rd_en || mem_wr_en) && (mem_addr[3:0] > 4'd8)) proto_bad = 1'b1;
      if (mem_rd_en) rd_count++;
      if (mem_wr_en) begin
        n_wr++;
        wr_cycle = cyc;
        got = {best_next, mem_addr, mem_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got best/addr/data %h, required none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL write_data: got best/addr/data %h, required %h", got, want);
          end
        end
      end
      if (done) begin
        done_cycle = cyc;
        saw_err = err;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (done_cycle == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles, required done");
    end
    checks++;
    if (proto_bad !== 1'b0) begin
      errors++;
      $display("FAIL mem_protocol: overlapping strobes or slot>8 seen, required none");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_missing: %0d expected writes left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; state = 8'h11; action = 4'd2; next_state = 8'h22;
    reward = 16'h0100; terminal = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_rd_en, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 00000", {busy, done, err, mem_rd_en, mem_wr_en});
    end
    checks++;
    if ({mem_addr, mem_wdata, best_next, q_new} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {mem_addr, mem_wdata, best_next, q_new});
    end
    checks++;
    if (dbg_state !== 3'(IDLE)) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_override: busy %b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    int wc, rc, nw, dc;
    logic e;
    set_row(8'h12, 16'h0010, 16'hFF00, 16'h0200, 16'h0300, 16'h07FF,
            16'h0800, 16'h8000, 16'h0100, 16'h0000);
    mem[{8'h34, 4'd3}] = 16'h0100;
    run_txn(8'h34, 4'd3, 8'h12, 16'h0400, 1'b0, 0, wc, rc, nw, dc, e);
    checks++;
    if (wc != 13 || dc != 13) begin
      errors++;
      $display("FAIL basic_latency: write %0d done %0d, required 13/13", wc, dc);
    end
    checks++;
    if (rc != 10 || nw != 1 || e !== 1'b0) begin
      errors++;
      $display("FAIL basic_counts: reads %0d writes %0d err %b, required 10/1/0", rc, nw, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (best_next !== 4'd5 || q_new !== 16'h0380) begin
      errors++;
      $display("FAIL basic_hold: best %0d q_new %h, required 5/0380", best_next, q_new);
    end
  endtask

  task automatic test_tie();
    int wc, rc, nw, dc;
    logic e;
    set_row(8'h40, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
            16'h0200, 16'h0200, 16'h0200, 16'h0200);
    mem[{8'h41, 4'd7}] = 16'h0000;
    run_txn(8'h41, 4'd7, 8'h40, 16'h0000, 1'b0, 0, wc, rc, nw, dc, e);
    checks++;
    if (best_next !== 4'd0 || q_new !== 16'h0070) begin
      errors++;
      $display("FAIL tie: best %0d q_new %h, required 0/0070", best_next, q_new);
    end
  endtask

  task automatic test_terminal();
    int wc, rc, nw, dc;
    logic e;
    mem[{8'h55, 4'd8}] = 16'h0100;
    run_txn(8'h55, 4'd8, 8'h12, 16'hFC00, 1'b1, 0, wc, rc, nw, dc, e);
    checks++;
    if (wc != 4 || rc != 1) begin
      errors++;
      $display("FAIL terminal_timing: write cycle %0d reads %0d, required 4/1", wc, rc);
    end
    checks++;
    if (q_new !== 16'hFFC0 || best_next !== 4'd0) begin
      errors++;
      $display("FAIL terminal_value: q_new %h best %0d, required FFC0/0", q_new, best_next);
    end
  endtask

  task automatic test_saturation();
    int wc, rc, nw, dc;
    logic e;
    set_row(8'h60, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000);
    mem[{8'h61, 4'd1}] = 16'h7F00;
    run_txn(8'h61, 4'd1, 8'h60, 16'h7F00, 1'b0, 0, wc, rc, nw, dc, e);
    checks++;
    if (q_new !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_high: q_new %h, required 7FFF", q_new);
    end
    mem[{8'h62, 4'd0}] = 16'h8000;
    run_txn(8'h62, 4'd0, 8'h60, 16'h8000, 1'b1, 0, wc, rc, nw, dc, e);
    checks++;
    if (q_new !== 16'h8000) begin
      errors++;
      $display("FAIL sat_low: q_new %h, required 8000", q_new);
    end
  endtask

  task automatic test_bad_action();
    int wc, rc, nw, dc;
    logic e;
    run_txn(8'h70, 4'd9, 8'h71, 16'h0100, 1'b0, 0, wc, rc, nw, dc, e);
    checks++;
    if (dc != 1 || e !== 1'b1 || rc != 0 || nw != 0) begin
      errors++;
      $display("FAIL bad_action: done cyc %0d err %b reads %0d writes %0d, required 1/1/0/0",
               dc, e, rc, nw);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q_new !== 16'h8000) begin
      errors++;
      $display("FAIL bad_action_after: busy %b done %b q_new %h, required 0/0/8000",
               busy, done, q_new);
    end
  endtask

  task automatic test_back_to_back();
    int wc, rc, nw, dc;
    logic e;
    logic [SW-1:0] s, ns;
    logic term;
    mem[{8'h13, 4'd4}] = 16'h0042;
    run_txn(8'h13, 4'd4, 8'h12, 16'h0010, 1'b0, 4, wc, rc, nw, dc, e);
    checks++;
    if (nw != 1 || wc != 13) begin
      errors++;
      $display("FAIL repulse_ignored: writes %0d at cycle %0d, required 1 at 13", nw, wc);
    end
    for (int i = 0; i < 6; i++) begin
      s  = 8'($urandom_range(0, 255));
      ns = 8'($urandom_range(0, 255));
      term = 1'($urandom_range(0, 1));
      for (int k = 0; k < 9; k++) mem[{ns, 4'(k)}] = 16'($urandom_range(0, 65535));
      for (int k = 0; k < 9; k++) mem[{s, 4'(k)}] = 16'($urandom_range(0, 65535));
      run_txn(s, 4'($urandom_range(0, 8)), ns, 16'($urandom_range(0, 65535)), term, 0,
              wc, rc, nw, dc, e);
      checks++;
      if (wc != (term ? 4 : 13)) begin
        errors++;
        $display("FAIL random_latency[%0d]: write cycle %0d, required %0d", i, wc, term ? 4 : 13);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wc, rc, nw, dc;
    logic e;
    logic wr_seen;
    wr_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; state = 8'h34; action = 4'd3; next_state = 8'h12;
    reward = 16'h0400; terminal = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wr_en) wr_seen = 1'b1;
      if (cyc == 6) rst = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, best_next, q_new} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, required 0",
               {busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, best_next, q_new});
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_wr_en) wr_seen = 1'b1;
    end
    checks++;
    if (wr_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: write seen %b, required 0", wr_seen);
    end
    mem[{8'h34, 4'd3}] = 16'h0100;
    run_txn(8'h34, 4'd3, 8'h12, 16'h0400, 1'b0, 0, wc, rc, nw, dc, e);
    checks++;
    if (q_new !== 16'h0380 || wc != 13) begin
      errors++;
      $display("FAIL reset_mid_recover: q_new %h at cycle %0d, required 0380 at 13", q_new, wc);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    rst = 1'b1; start = 1'b0; state = '0; action = '0; next_state = '0;
    reward = '0; terminal = 1'b0;
    test_reset();
    test_basic();
    test_terminal();
    test_tie();
    test_saturation();
    test_bad_action();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_update.md
Q_UPDATE -- requirements
Module: q_update

Interface
REQ-001 SHALL have parameter STATE_W, default 8: state index width.
REQ-002 SHALL have parameter ALPHA_SHIFT, default 2: learning rate alpha = 2^-ALPHA_SHIFT.
REQ-003 SHALL have parameter GAMMA_SHIFT, default 3: discount gamma = 1 - 2^-GAMMA_SHIFT.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports: start in 1 (request pulse); state in STATE_W (current state s); action in 4 (taken action a, valid 0..8); next_state in STATE_W (s'); reward in 16 (signed Q8.8); terminal in 1 (s' is terminal).
REQ-007 SHALL have ports: mem_addr out STATE_W+4 = {state, slot}; mem_rd_en out 1; mem_rdata in 16 (valid the cycle after mem_rd_en); mem_wr_en out 1; mem_wdata out 16.
REQ-008 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (qualified by done); best_next out 4 (argmax slot of s'); q_new out 16 (written value).

Function
REQ-009 SHALL be an FSM with states IDLE, SCAN, READ_CUR, CUR_WAIT, CALC, WRITE.
REQ-010 SHALL accept start only in IDLE; capture state, action, next_state, reward and terminal on that edge; ignore start in all other states.
REQ-011 With action > 8 at start: no memory access; done=1, err=1 on the next cycle; return to IDLE.
REQ-012 SCAN SHALL last 9 cycles, with mem_rd_en=1 and mem_addr={next_state, k} for k=0..8 in order.
REQ-013 SHALL track max Q(s') over the 9 returned words as signed compare; ties keep the lowest slot; result goes to best_next and maxq.
REQ-014 READ_CUR SHALL issue mem_rd_en with mem_addr={state, action}; CUR_WAIT SHALL capture Q(s,a) from mem_rdata.
REQ-015 When terminal=1, SCAN SHALL be skipped (IDLE->READ_CUR), with maxq=0 and best_next=0.
REQ-016 CALC SHALL compute all 18-bit signed values: target = reward + maxq - (maxq >>> GAMMA_SHIFT); delta = target - Q; sum = Q + (delta >>> ALPHA_SHIFT); saturate to [0x8000, 0x7FFF].
REQ-017 WRITE SHALL hold mem_wr_en=1, mem_addr={state, action}, mem_wdata=q_new, done=1, err=0 for exactly one cycle, then go to IDLE.
REQ-018 Latency: start at edge E0 gives WRITE in cycle 13 when non-terminal and cycle 4 when terminal. busy SHALL be 1 from cycle 1 through WRITE inclusive.
REQ-019 mem_rd_en and mem_wr_en SHALL never both be high; both SHALL be 0 in IDLE. Unused slots 9..15 SHALL never be addressed.
REQ-020 best_next and q_new SHALL hold their last values until the next accepted start.

Reset
REQ-021 On rst=1 at a clock edge: FSM goes to IDLE. busy, done, err, mem_rd_en, mem_wr_en SHALL be 0. mem_addr, mem_wdata, best_next, q_new and internal registers SHALL be 0.
REQ-022 rst SHALL override start in the same cycle. Reset mid-operation SHALL abort with no memory write.

Structure
REQ-023 Shared package q_pkg SHALL hold Q_W=16, ACT_W=4, N_ACT=9, the FSM state enum, and the default ALPHA_SHIFT and GAMMA_SHIFT values.
REQ-024 CALC arithmetic and saturation SHALL live in the combinational sub-module q_update_alu; the FSM, scan/max and memory sequencing stay in q_update.

Verification
REQ-025 Q(s,a)=0x0100, reward=0x0400, row s' max 0x0800 at slot 5, terminal=0 -> best_next=5, mem_wdata=0x0380, write in cycle 13.
REQ-026 Row s' all 0x0200 (tie) -> best_next=0; Q=0x0000, reward=0 -> q_new=0x0070.
REQ-027 terminal=1, Q=0x0100, reward=0xFC00 -> no SCAN reads, q_new=0xFFC0, write in cycle 4.
REQ-028 Q=0x7F00, reward=0x7F00, max Q(s')=0x7F00 -> q_new saturates to 0x7FFF; Q=0x8000, reward=0x8000, terminal=1 -> 0x8000.
REQ-029 action=9 -> no rd/wr strobes, done=1 and err=1 in cycle 1; start re-pulsed during SCAN -> ignored, single write.
REQ-030 rst asserted in cycle 6 of SCAN -> all outputs 0 next cycle, no write ever issued; new start then completes normally.
